softmax_feeder: RTL and testbench

- Sequencer in front of the Softmax classifier stage.
- Accepts a stream of signed partial sums from the dense output layer over a valid/ready handshake.
- Replays them as the Softmax input protocol: a `sum` value with a one-cycle `accumulate_en` strobe per partial, and a one-cycle `store_en` strobe after every SUM_PER_NODE partials.
- Pulses `frame_done` after NUM_NODES nodes.

---
 rtl/softmax_feeder.sv | 114 +++++++++++
 tb/tb_softmax_feeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_feeder.sv
// Sequencer that turns a valid/ready stream of dense-layer partial sums into
// the Softmax accumulate/store strobe protocol, one frame of NUM_NODES nodes per start.
module softmax_feeder #(
  parameter int WIDTH        = 32,
  parameter int NUM_NODES    = 6,
  parameter int SUM_PER_NODE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             sum,
  output logic                         accumulate_en,
  output logic                         store_en,
  output logic [$clog2(NUM_NODES)-1:0] node_idx,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int NODE_W = $clog2(NUM_NODES);
  localparam int PART_W = $clog2(SUM_PER_NODE + 1);
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);
  localparam logic [PART_W-1:0] LAST_PART = PART_W'(SUM_PER_NODE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    ACC,
    GAP,
    STORE,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [PART_W-1:0]  part_cnt_q, part_cnt_d;
  logic [NODE_W-1:0]  node_cnt_q, node_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      part_cnt_q <= '0;
      node_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      part_cnt_q <= part_cnt_d;
      node_cnt_q <= node_cnt_d;
    end
  end

  // sum_d defaults to zero so the captured value is visible only during ACC.
  always_comb begin
    state_d    = state_q;
    sum_d      = '0;
    part_cnt_d = part_cnt_q;
    node_cnt_d = node_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          part_cnt_d = '0;
          node_cnt_d = '0;
          state_d    = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (in_valid) begin
          sum_d   = in_data;
          state_d = ACC;
        end
      end
      ACC: begin
        if (part_cnt_q == LAST_PART) begin
          part_cnt_d = '0;
          state_d    = GAP;
        end else begin
          part_cnt_d = part_cnt_q + 1'b1;
          state_d    = WAIT_IN;
        end
      end
      GAP: begin
        state_d = STORE;
      end
      STORE: begin
        if (node_cnt_q == LAST_NODE) begin
          state_d = DONE;
        end else begin
          node_cnt_d = node_cnt_q + 1'b1;
          state_d    = WAIT_IN;
        end
      end
      DONE: begin
        node_cnt_d = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is decoded from registers only; in_valid/in_data never reach them.
  assign in_ready      = (state_q == WAIT_IN);
  assign accumulate_en = (state_q == ACC);
  assign store_en      = (state_q == STORE);
  assign frame_done    = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign sum           = sum_q;
  assign node_idx      = node_cnt_q;

endmodule

// File: tb/tb_softmax_feeder.sv
// Directed bench for softmax_feeder: accepted partials go into a scoreboard queue
// and are popped against each accumulate strobe, with protocol invariants checked every cycle.
module tb_softmax_feeder;

  localparam int WIDTH        = 32;
  localparam int NUM_NODES    = 6;
  localparam int SUM_PER_NODE = 3;
  localparam int PARTIALS     = NUM_NODES * SUM_PER_NODE;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start;
  logic [WIDTH-1:0]             in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             sum;
  logic                         accumulate_en;
  logic                         store_en;
  logic [$clog2(NUM_NODES)-1:0] node_idx;
  logic                         busy;
  logic                         frame_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ[$];
  logic [31:0] src[PARTIALS];
  int          accFrame;
  int          storeFrame;
  int          accSinceStore;
  logic        prevAcc;
  logic        prevLow;

  softmax_feeder #(
    .WIDTH(WIDTH),
    .NUM_NODES(NUM_NODES),
    .SUM_PER_NODE(SUM_PER_NODE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sum(sum),
    .accumulate_en(accumulate_en),
    .store_en(store_en),
    .node_idx(node_idx),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expVal);
    end
  endtask

  task automatic clearTracking();
    accFrame      = 0;
    storeFrame    = 0;
    accSinceStore = 0;
    prevAcc       = 1'b0;
    prevLow       = 1'b1;
  endtask

  // Scoreboard pop plus per-cycle strobe invariants.
  task automatic monitor();
    logic [31:0] e;
    if (accumulate_en) begin
      check("accHasExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("sumValue", sum, e);
      end
      check("accNodeIdx", 32'(node_idx), storeFrame);
      check("accBackToBack", 32'(prevAcc), 32'd0);
      accFrame++;
      accSinceStore++;
    end else begin
      check("sumIdleZero", sum, 32'd0);
    end
    if (store_en) begin
      check("storeOverlap", 32'(accumulate_en), 32'd0);
      check("storeGap", 32'(prevLow), 32'd1);
      check("storePartials", accSinceStore, SUM_PER_NODE);
      check("storeNodeIdx", 32'(node_idx), storeFrame);
      storeFrame++;
      accSinceStore = 0;
    end
    prevAcc = accumulate_en;
    prevLow = !accumulate_en && !store_en;
  endtask

  task automatic cycle(input logic st, input logic v, input logic [31:0] d, output logic hs);
    start    = st;
    in_valid = v;
    in_data  = d;
    hs = v && in_ready && !rst;
    if (hs) expQ.push_back(d);
    @(posedge clk);
    #1;
    monitor();
  endtask

  // Reset is applied together with start and in_valid so that rst must win.
  task automatic doReset();
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    check("rstInReady", 32'(in_ready), 32'd0);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstAcc", 32'(accumulate_en), 32'd0);
    check("rstStore", 32'(store_en), 32'd0);
    check("rstFrameDone", 32'(frame_done), 32'd0);
    check("rstNodeIdx", 32'(node_idx), 32'd0);
    check("rstSum", sum, 32'd0);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    clearTracking();
  endtask

  task automatic idleCycles(input int cnt, input logic v);
    logic hs;
    for (int i = 0; i < cnt; i++) begin
      cycle(1'b0, v, 32'h1234_5678, hs);
      check("idleReady", 32'(in_ready), 32'd0);
      check("idleBusy", 32'(busy), 32'd0);
      check("idleAcc", 32'(accumulate_en), 32'd0);
      check("idleStore", 32'(store_en), 32'd0);
    end
    check("idleNothingQueued", expQ.size(), 32'd0);
  endtask

  // mode 0: in_valid held high; 1: pattern 1,0,0; 2: random in_valid.
  task automatic runFrame(input int mode, input bit spurious, input bit abort, output int n);
    logic hs;
    logic v;
    logic st;
    int   ptr;
    clearTracking();
    cycle(1'b1, 1'b0, 32'h0, hs);
    n = 1;
    check("startBusy", 32'(busy), 32'd1);
    check("startReady", 32'(in_ready), 32'd1);
    ptr = 0;
    while (!frame_done && n < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 3 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      st = spurious && (storeFrame == 3);
      cycle(st, v, (ptr < PARTIALS) ? src[ptr] : 32'hDEAD_BEEF, hs);
      if (hs) ptr++;
      n++;
      if (abort && storeFrame == 2 && accSinceStore == 2) break;
    end
    if (!abort) begin
      check("frameDone", 32'(frame_done), 32'd1);
      check("frameDoneBusy", 32'(busy), 32'd1);
      check("frameAccCount", accFrame, PARTIALS);
      check("frameStoreCount", storeFrame, NUM_NODES);
      check("frameConsumed", ptr, PARTIALS);
      check("frameQueueEmpty", expQ.size(), 32'd0);
      cycle(1'b1, 1'b1, 32'h0BAD_0BAD, hs);
      check("doneStartIgnored", 32'(busy), 32'd0);
      check("doneNodeIdxZero", 32'(node_idx), 32'd0);
      check("doneFrameDoneClear", 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    doReset();
    idleCycles(2, 1'b1);

    for (int i = 0; i < PARTIALS; i++) src[i] = 32'(i + 1);
    runFrame(0, 1'b0, 1'b0, n);
    check("basicLatency", n, 32'd49);

    src[0] = 32'hFFFF_FFFB;
    src[1] = 32'h0000_0007;
    src[2] = 32'h7FFF_FFFF;
    src[3] = 32'h8000_0000;
    for (int i = 4; i < PARTIALS; i++) src[i] = 32'(100 + i);
    runFrame(1, 1'b0, 1'b0, n);

    for (int i = 0; i < PARTIALS; i++) src[i] = 32'(i + 1);
    runFrame(0, 1'b0, 1'b1, n);
    doReset();
    idleCycles(3, 1'b0);
    runFrame(0, 1'b0, 1'b0, n);
    check("afterResetLatency", n, 32'd49);

    for (int i = 0; i < PARTIALS; i++) src[i] = 32'(200 + i);
    runFrame(0, 1'b1, 1'b0, n);
    check("spuriousLatency", n, 32'd49);
    idleCycles(3, 1'b1);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < PARTIALS; i++) src[i] = $urandom;
      runFrame(2, 1'b0, 1'b0, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
